mul_seq16: RTL



---
 rtl/mul_pkg.sv | 23 ++
 rtl/adder16bit.sv | 28 ++
 rtl/mul_seq16.sv | 102 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential shift-and-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_STEPS = 16;
  localparam int CNT_W     = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Step counter value on the final partial-product step of a run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/adder16bit.sv
// 16-bit adder with carry-in/out, built as four chained 4-bit ripple slices.
// Latency: purely combinational.
// Backpressure: none; always ready.
module adder16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out
);

  logic       carry;
  logic [4:0] nib;

  // Ripple the carry through the four nibble slices, low nibble first.
  always_comb begin
    carry = C_in;
    S     = '0;
    nib   = '0;
    for (int i = 0; i < 4; i++) begin
      nib          = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0000, carry};
      S[4*i +: 4]  = nib[3:0];
      carry        = nib[4];
    end
    C_out = carry;
  end

endmodule

// File: rtl/mul_seq16.sv
// Unsigned 16x16->32 multiplier: one shift-and-add step per clock on a shared adder16bit.
// Latency: 16 cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: start is accepted only when busy=0; start during a run is dropped.
module mul_seq16
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // The adder is fixed at 16 bits, so any other width cannot be built.
  if (WIDTH != MUL_W) begin : g_bad_width
    $error("mul_seq16: WIDTH must be 16");
  end

  state_t             state_q,  state_d;
  logic [MUL_W-1:0]   mcand_q,  mcand_d;
  logic [MUL_W-1:0]   acc_hi_q, acc_hi_d;
  logic [MUL_W-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic [MUL_W-1:0]   add_b;
  logic [MUL_W-1:0]   add_s;
  logic               add_co;

  // Adder operand B: the multiplicand when the current multiplier bit is set.
  always_comb begin
    add_b = acc_lo_q[0] ? mcand_q : '0;
  end

  adder16bit u_adder (
    .A     (acc_hi_q),
    .B     (add_b),
    .C_in  (1'b0),
    .S     (add_s),
    .C_out (add_co)
  );

  // Next-state for FSM and datapath: accept in IDLE/DONE, one step per RUN cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Shift {carry, sum, acc_lo} right by one; the carry lands in acc_hi[15].
        acc_hi_d = {add_co, add_s[MUL_W-1:1]};
        acc_lo_d = {add_s[0], acc_lo_q[MUL_W-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that discards any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = {acc_hi_q, acc_lo_q};

endmodule
